// File: rtl/fifo_uart_tx.sv
// Drains bytes from a registered-read FIFO and serializes each one as an
// 8N1 UART frame, LSB first, at CLKS_PER_BIT clocks per bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_rd_en,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [DW-1:0] shreg, shreg_nx;
  logic          tx_nx, done_nx, rd_en_nx, busy_nx;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shreg      <= shreg_nx;
      tx         <= tx_nx;
      frame_done <= done_nx;
      fifo_rd_en <= rd_en_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) state_nx = POP;
      end
      POP: state_nx = LOAD;
      LOAD: begin
        shreg_nx = fifo_rd_data;
        cnt_nx   = '0;
        idx_nx   = '0;
        state_nx = START;
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shreg_nx = shreg >> 1;
          idx_nx   = idx + 1'b1;
          if (idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe without any input-to-output combinational path.
  always_comb begin
    tx_nx    = 1'b1;
    done_nx  = 1'b0;
    rd_en_nx = 1'b0;
    busy_nx  = 1'b0;
    case (state_nx)
      START: tx_nx = 1'b0;
      DATA:  tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase
    done_nx  = (state_nx == STOP) && (cnt_nx == CNT_MAX);
    rd_en_nx = (state_nx == POP);
    busy_nx  = (state_nx != IDLE);
  end

endmodule
